prompt_streamer: RTL and testbench
==================================

# prompt_streamer

Sequencer that reads a fixed byte string out of the 16×8 on-chip prompt pROM and streams it, one byte per handshake, to a byte-serial transmitter such as the UART TX. Each `start` pulse replays the string once. The sequencer owns the pROM control pins (`ce`, `oce`, `reset`, `ad`). It undoes the LSB-first bit ordering used to store the bytes, so the transmitter receives normal ASCII (for example "echo>").

## Interface
- `PROMPT_LEN`, default 5: maximum number of bytes sent per run; legal range 1..16.
- `BASE_ADDR`, default 0: pROM address of the first byte, 4 bits.
- `BIT_REVERSE`, default 1: when 1, each fetched byte is bit-reversed (bit i becomes bit 7−i) before it is sent.
- `STOP_ON_ZERO`, default 1: when 1, a fetched byte equal to 0x00 ends the run early; the 0x00 is not sent.
- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request one replay; sampled only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a run ends.
- `rom_ce`  out  1  pROM clock enable.
- `rom_oce`  out  1  pROM output enable; equals `rom_ce`.
- `rom_reset`  out  1  pROM reset; equals `~rst_n` (combinational).
- `rom_ad`  out  4  pROM address.
- `rom_dout`  in  8  pROM read data; registered inside the pROM, valid one cycle after `rom_ce`.
- `tx_data`  out  8  byte to transmit.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  transmitter accepts the byte.

## Operation
- FSM states: IDLE, FETCH, LOAD, SEND, DONE.
- IDLE, with `start` = 1: clear the index to 0 and go to FETCH.
- FETCH: drive `rom_ce` = 1 and `rom_ad` = (`BASE_ADDR` + idx) mod 16, so addresses wrap past 15 to 0. Go to LOAD.
- LOAD: `rom_dout` is valid.
  - If `STOP_ON_ZERO` = 1 and `rom_dout` = 0x00, go to DONE.
  - Otherwise register `tx_data` = `BIT_REVERSE` ? bitrev(`rom_dout`) : `rom_dout`, and go to SEND.
- SEND: hold `tx_valid` = 1 with `tx_data` stable until a cycle with `tx_ready` = 1.
  - On that transfer, if idx = `PROMPT_LEN`−1, go to DONE.
  - Otherwise increment idx and go to FETCH.
- DONE: `done` = 1 for exactly one cycle, then go to IDLE.
- `start` is ignored in every state except IDLE, including the DONE cycle; it is not queued.
- idx is 4 bits wide and never exceeds `PROMPT_LEN`−1.
- Outputs outside their active states: `rom_ce` = 0 and `rom_ad` holds its last value. `tx_data` holds its last value but is meaningful only while `tx_valid` = 1.
- Reset (`rst_n` low at any time, including mid-run):
  - FSM goes to IDLE and idx to 0 immediately.
  - `busy`, `done`, `rom_ce`, `rom_oce`, `tx_valid` = 0.
  - `rom_ad`, `tx_data` = 0.
  - `rom_reset` = 1.
  - Any byte in flight is dropped. After release, nothing happens until a new `start`.

## Timing
- `start` high in IDLE at cycle N:
  - FETCH in N+1, LOAD in N+2, first `tx_valid` in N+3.
- With `tx_ready` held high, each byte costs 3 cycles.
  - The default 5-byte run occupies cycles N+1..N+15, with `done` in N+16.
  - `busy` is high from N+1 through N+16.
- Each cycle `tx_ready` is low in SEND adds one cycle.
- `tx_valid` never drops before the transfer completes, and never rises outside SEND.

## Structure
- Shared package holds:
  - the state enum;
  - constants `PROM_DEPTH` = 16 and `PROM_AW` = 4;
  - a `bitrev8` function.
- No sub-module. The pROM is instantiated beside this block at top level and connected through the `rom_*` ports.

## Test plan
- Default parameters, pROM model loaded with A6 C6 16 F6 7C 00…, `tx_ready` = 1, `start` pulse → `tx_data` sequence 0x65 0x63 0x68 0x6F 0x3E on cycles N+3, +6, +9, +12, +15; `done` at N+16.
- Same run with `tx_ready` low for 4 cycles on byte 2 → 0x63 held with `tx_valid` high for 5 cycles, no byte lost, `done` delayed by 4 cycles.
- `PROMPT_LEN` = 16, `STOP_ON_ZERO` = 1 → byte at address 5 is 0x00, run ends after 5 bytes, 0x00 never sent.
- `BASE_ADDR` = 14, `PROMPT_LEN` = 4, `STOP_ON_ZERO` = 0 → `rom_ad` sequence 14, 15, 0, 1.
- `start` re-pulsed during SEND and during DONE → ignored; exactly one run.
- `rst_n` low during the third SEND → `tx_valid` and `busy` drop asynchronously. After release, a new `start` replays from 0x65.

Source files
------------

// File: rtl/prompt_streamer_pkg.sv
// Shared types, pROM geometry and helpers for the prompt streamer.
// The pROM stores each byte LSB-first; bitrev8 restores normal bit order.
package prompt_streamer_pkg;

  localparam int PROM_DEPTH = 16;
  localparam int PROM_AW    = 4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SEND,
    DONE
  } state_t;

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/prompt_streamer.sv
// Replays a fixed byte string from the on-chip prompt pROM to a byte-serial
// transmitter, one byte per valid/ready handshake, once per start pulse.
module prompt_streamer
  import prompt_streamer_pkg::*;
#(
  parameter int unsigned        PROMPT_LEN   = 5,
  parameter logic [PROM_AW-1:0] BASE_ADDR    = '0,
  parameter bit                 BIT_REVERSE  = 1'b1,
  parameter bit                 STOP_ON_ZERO = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               rom_ce,
  output logic               rom_oce,
  output logic               rom_reset,
  output logic [PROM_AW-1:0] rom_ad,
  input  logic [7:0]         rom_dout,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready
);

  localparam logic [PROM_AW-1:0] LAST_IDX = PROM_AW'(PROMPT_LEN - 1);

  state_t             state, next_state;
  logic [PROM_AW-1:0] idx, next_idx;
  logic               load_tx;

  always_comb begin
    next_state = state;
    next_idx   = idx;
    load_tx    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          next_idx   = '0;
          next_state = FETCH;
        end
      end
      FETCH: next_state = LOAD;
      LOAD: begin
        // pROM data registered on the FETCH edge is valid here
        if (STOP_ON_ZERO && rom_dout == 8'h00) begin
          next_state = DONE;
        end else begin
          load_tx    = 1'b1;
          next_state = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (idx == LAST_IDX) begin
            next_state = DONE;
          end else begin
            next_idx   = idx + 1'b1;
            next_state = FETCH;
          end
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Address is latched on entry to FETCH so it holds between fetches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      rom_ad  <= '0;
      tx_data <= '0;
    end else begin
      state <= next_state;
      idx   <= next_idx;
      if (next_state == FETCH) rom_ad <= BASE_ADDR + next_idx;
      if (load_tx) tx_data <= BIT_REVERSE ? bitrev8(rom_dout) : rom_dout;
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign rom_ce    = (state == FETCH);
  assign rom_oce   = rom_ce;
  assign rom_reset = ~rst_n;
  assign tx_valid  = (state == SEND);

endmodule

// File: tb/tb_prompt_streamer.sv
// Scoreboard bench for prompt_streamer: three differently parameterised
// instances, each with its own pROM model, checked by a per-cycle monitor.
module tb_prompt_streamer;

  localparam int CFG_LEN[3]  = '{5, 16, 4};
  localparam int CFG_BASE[3] = '{0, 0, 14};
  localparam int CFG_REV[3]  = '{1, 1, 0};
  localparam int CFG_STOP[3] = '{1, 1, 0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start[3], busy[3], done[3], rom_ce[3], rom_oce[3], rom_reset[3];
  logic       tx_valid[3], tx_ready[3];
  logic [3:0] rom_ad[3];
  logic [7:0] rom_dout[3], tx_data[3];
  logic [7:0] rom_mem[3][16];

  logic [7:0] exp_q[3][$];
  logic [3:0] ad_q[3][$];

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int run_n[3], next_rise[3], next_fetch[3], exp_done[3], last_done[3];
  int low_from[3], low_to[3];
  bit active[3], zero_stop[3], rand_ready[3], prev_valid[3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered pROM model: data appears the cycle after rom_ce
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rom_reset[k]) rom_dout[k] <= 8'h00;
      else if (rom_ce[k]) rom_dout[k] <= rom_mem[k][rom_ad[k]];
    end
  end

  prompt_streamer #(.PROMPT_LEN(5), .BASE_ADDR(4'd0), .BIT_REVERSE(1'b1), .STOP_ON_ZERO(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .rom_ce(rom_ce[0]), .rom_oce(rom_oce[0]), .rom_reset(rom_reset[0]), .rom_ad(rom_ad[0]),
    .rom_dout(rom_dout[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]));

  prompt_streamer #(.PROMPT_LEN(16), .BASE_ADDR(4'd0), .BIT_REVERSE(1'b1), .STOP_ON_ZERO(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .rom_ce(rom_ce[1]), .rom_oce(rom_oce[1]), .rom_reset(rom_reset[1]), .rom_ad(rom_ad[1]),
    .rom_dout(rom_dout[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]));

  prompt_streamer #(.PROMPT_LEN(4), .BASE_ADDR(4'd14), .BIT_REVERSE(1'b0), .STOP_ON_ZERO(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .busy(busy[2]), .done(done[2]),
    .rom_ce(rom_ce[2]), .rom_oce(rom_oce[2]), .rom_reset(rom_reset[2]), .rom_ad(rom_ad[2]),
    .rom_dout(rom_dout[2]), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]));

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name, input string detail);
    total++;
    bad++;
    $display("[TB] FAIL %s: got %s", name, detail);
  endtask

  // Reference bit reversal: read source bits LSB-first into an MSB-first accumulator
  function automatic logic [7:0] revByte(input logic [7:0] b);
    int v = 0;
    for (int j = 0; j < 8; j++) v = v * 2 + ((int'(b) >> j) & 1);
    return 8'(v);
  endfunction

  task automatic checkReset(input int k);
    string p = $sformatf("ch%0d_rst_", k);
    checkOutput({p, "busy"}, 32'(busy[k]), 32'd0);
    checkOutput({p, "done"}, 32'(done[k]), 32'd0);
    checkOutput({p, "rom_ce"}, 32'(rom_ce[k]), 32'd0);
    checkOutput({p, "rom_oce"}, 32'(rom_oce[k]), 32'd0);
    checkOutput({p, "tx_valid"}, 32'(tx_valid[k]), 32'd0);
    checkOutput({p, "rom_ad"}, 32'(rom_ad[k]), 32'd0);
    checkOutput({p, "tx_data"}, 32'(tx_data[k]), 32'd0);
    checkOutput({p, "rom_reset"}, 32'(rom_reset[k]), 32'd1);
  endtask

  task automatic monitorStep(input int k);
    string p = $sformatf("ch%0d_", k);
    checkOutput({p, "busy"}, 32'(busy[k]), 32'(active[k] && cyc > run_n[k]));
    checkOutput({p, "done"}, 32'(done[k]), 32'(cyc == exp_done[k]));
    checkOutput({p, "rom_ce"}, 32'(rom_ce[k]), 32'(cyc == next_fetch[k]));
    checkOutput({p, "rom_oce"}, 32'(rom_oce[k]), 32'(cyc == next_fetch[k]));
    if (rom_ce[k]) begin
      if (ad_q[k].size() == 0) failNow({p, "fetch"}, "fetch with no expected address");
      else begin
        checkOutput({p, "rom_ad"}, 32'(rom_ad[k]), 32'(ad_q[k][0]));
        ad_q[k].delete(0);
      end
    end
    if (tx_valid[k]) begin
      if (!prev_valid[k]) checkOutput({p, "valid_rise_cycle"}, cyc, next_rise[k]);
      if (exp_q[k].size() == 0) failNow({p, "tx_valid"}, "valid with no expected byte");
      else begin
        checkOutput({p, "tx_data"}, 32'(tx_data[k]), 32'(exp_q[k][0]));
        if (tx_ready[k]) begin
          exp_q[k].delete(0);
          next_rise[k] = cyc + 3;
          if (exp_q[k].size() != 0 || zero_stop[k]) next_fetch[k] = cyc + 1;
          if (exp_q[k].size() == 0) exp_done[k] = zero_stop[k] ? cyc + 3 : cyc + 1;
        end
      end
    end
    if (done[k]) last_done[k] = cyc;
    if (done[k] || cyc == exp_done[k]) begin
      active[k]   = 1'b0;
      exp_done[k] = -1;
    end
    prev_valid[k] = tx_valid[k];
  endtask

  task automatic waitUntil(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input int k, input bit zs, input int nbytes);
    @(posedge clk);
    #1;
    start[k]      = 1'b1;
    run_n[k]      = cyc;
    active[k]     = 1'b1;
    zero_stop[k]  = zs;
    last_done[k]  = -1;
    next_fetch[k] = cyc + 1;
    next_rise[k]  = cyc + 3;
    exp_done[k]   = (nbytes == 0) ? cyc + 3 : -1;
    @(posedge clk);
    #1;
    start[k] = 1'b0;
  endtask

  task automatic waitDone(input int k);
    int t = 0;
    while (active[k] && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (active[k]) begin
      failNow($sformatf("ch%0d_run_timeout", k), "no end of run within 3000 cycles");
      active[k] = 1'b0;
    end
  endtask

  task automatic pushEcho(input int k);
    exp_q[k].push_back(8'h65);
    exp_q[k].push_back(8'h63);
    exp_q[k].push_back(8'h68);
    exp_q[k].push_back(8'h6F);
    exp_q[k].push_back(8'h3E);
  endtask

  task automatic pushAddr(input int base, input int count, input int k);
    for (int i = 0; i < count; i++) ad_q[k].push_back(4'((base + i) % 16));
  endtask

  task automatic loadPrompt(input int k);
    for (int a = 0; a < 16; a++) rom_mem[k][a] = 8'h00;
    rom_mem[k][0] = 8'hA6;
    rom_mem[k][1] = 8'hC6;
    rom_mem[k][2] = 8'h16;
    rom_mem[k][3] = 8'hF6;
    rom_mem[k][4] = 8'h7C;
  endtask

  // Reference model: walk the string from BASE_ADDR, wrapping mod 16
  task automatic modelRun(input int k);
    int n = 0;
    bit zs = 1'b0;
    logic [3:0] a;
    logic [7:0] b;
    for (int i = 0; i < CFG_LEN[k]; i++) begin
      a = 4'((CFG_BASE[k] + i) % 16);
      ad_q[k].push_back(a);
      b = rom_mem[k][a];
      if (CFG_STOP[k] == 1 && b == 8'h00) begin
        zs = 1'b1;
        break;
      end
      exp_q[k].push_back(CFG_REV[k] == 1 ? revByte(b) : b);
      n++;
    end
    applyStimulus(k, zs, n);
  endtask

  initial begin
    int n;
    int k;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0; tx_ready[i] = 1'b1; rand_ready[i] = 1'b0;
      active[i] = 1'b0; zero_stop[i] = 1'b0; prev_valid[i] = 1'b0;
      run_n[i] = 0; next_rise[i] = -1; next_fetch[i] = -1; exp_done[i] = -1;
      last_done[i] = -1; low_from[i] = -1; low_to[i] = -1;
      loadPrompt(i);
    end

    fork
      forever begin
        @(negedge clk);
        if (!rst_n) for (int j = 0; j < 3; j++) prev_valid[j] = 1'b0;
        else for (int j = 0; j < 3; j++) monitorStep(j);
      end
      forever begin
        @(posedge clk);
        #1;
        for (int j = 0; j < 3; j++)
          tx_ready[j] = rand_ready[j] ? ($urandom_range(0, 3) != 0)
                                      : !(cyc >= low_from[j] && cyc <= low_to[j]);
      end
    join_none

    #2 rst_n = 1'b0;
    #1 for (int i = 0; i < 3; i++) checkReset(i);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Default run; start re-pulsed during SEND and during DONE must be ignored
    pushEcho(0);
    pushAddr(0, 5, 0);
    applyStimulus(0, 1'b0, 5);
    n = run_n[0];
    waitUntil(n + 3);  start[0] = 1'b1;
    waitUntil(n + 4);  start[0] = 1'b0;
    waitUntil(n + 16); start[0] = 1'b1;
    waitUntil(n + 17); start[0] = 1'b0;
    waitDone(0);
    checkOutput("ch0_done_cycle", 32'(last_done[0] - n), 32'd16);
    repeat (8) @(posedge clk);
    #1;

    // Byte 2 stalled for four cycles
    pushEcho(0);
    pushAddr(0, 5, 0);
    applyStimulus(0, 1'b0, 5);
    n = run_n[0];
    low_from[0] = n + 6;
    low_to[0]   = n + 9;
    waitDone(0);
    checkOutput("ch0_stall_done_cycle", 32'(last_done[0] - n), 32'd20);
    low_from[0] = -1;
    low_to[0]   = -1;

    // 16-byte limit, early stop on the 0x00 at address 5
    pushEcho(1);
    pushAddr(0, 6, 1);
    applyStimulus(1, 1'b1, 5);
    n = run_n[1];
    waitDone(1);
    checkOutput("ch1_zero_stop_done_cycle", 32'(last_done[1] - n), 32'd18);

    // Address wrap 14,15,0,1 with raw bytes and zero passed through
    rom_mem[2][14] = 8'h12;
    rom_mem[2][15] = 8'h00;
    rom_mem[2][0]  = 8'hA5;
    rom_mem[2][1]  = 8'h3C;
    exp_q[2].push_back(8'h12);
    exp_q[2].push_back(8'h00);
    exp_q[2].push_back(8'hA5);
    exp_q[2].push_back(8'h3C);
    pushAddr(14, 4, 2);
    applyStimulus(2, 1'b0, 4);
    n = run_n[2];
    waitDone(2);
    checkOutput("ch2_wrap_done_cycle", 32'(last_done[2] - n), 32'd13);

    // Reset during the third SEND, then replay from the first byte
    pushEcho(0);
    pushAddr(0, 5, 0);
    applyStimulus(0, 1'b0, 5);
    n = run_n[0];
    waitUntil(n + 9);
    #1 rst_n = 1'b0;
    #1 checkReset(0);
    exp_q[0].delete();
    ad_q[0].delete();
    active[0] = 1'b0;
    exp_done[0] = -1;
    next_fetch[0] = -1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    pushEcho(0);
    pushAddr(0, 5, 0);
    applyStimulus(0, 1'b0, 5);
    n = run_n[0];
    waitDone(0);
    checkOutput("ch0_replay_done_cycle", 32'(last_done[0] - n), 32'd16);

    // Random pROM contents and random back-pressure against the model
    for (int it = 0; it < 30; it++) begin
      k = $urandom_range(0, 2);
      for (int a = 0; a < 16; a++)
        rom_mem[k][a] = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      rand_ready[k] = 1'b1;
      modelRun(k);
      waitDone(k);
      rand_ready[k] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end

    for (int i = 0; i < 3; i++) begin
      if (exp_q[i].size() != 0 || ad_q[i].size() != 0)
        failNow($sformatf("ch%0d_leftover", i), "expected items never consumed");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
